// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue controller and its command FIFO.
// A command is the full {s,m,x,y} tuple driven onto the combinational ALU.
package alu_pkg;

    localparam int OPND_W = 8;
    localparam int RES_W  = 16;

    typedef enum logic [1:0] {
        ARITH = 2'b00,
        SHIFT = 2'b01,
        COMP  = 2'b10,
        LOGIC = 2'b11
    } alu_unit_e;

    typedef struct packed {
        alu_unit_e         s;
        logic [1:0]        m;
        logic [OPND_W-1:0] x;
        logic [OPND_W-1:0] y;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        RESP   = 2'b10
    } issue_state_e;

    // Operation tag echoed with each response: {unit select, sub-operation}.
    function automatic logic [3:0] op_tag(input alu_cmd_t cmd);
        return {cmd.s, cmd.m};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO without fall-through: an entry written on
// one edge becomes visible at the read side only after that edge.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type data_t = alu_cmd_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  data_t push_data,
    input  logic  pop,
    output data_t pop_data,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("alu_cmd_fifo: DEPTH must be a power of two and at least 2");
    end

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered commands to a combinational ALU from registers, waits a fixed
// settle time, samples the result and returns it on a valid/ready stream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_s,
    input  logic [1:0]        cmd_m,
    input  logic [OPND_W-1:0] cmd_x,
    input  logic [OPND_W-1:0] cmd_y,
    output logic [OPND_W-1:0] alu_x,
    output logic [OPND_W-1:0] alu_y,
    output logic [1:0]        alu_m,
    output logic [1:0]        alu_s,
    input  logic [RES_W-1:0]  alu_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [3:0]        rsp_op,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYCLES must be at least 1");
    end

    issue_state_e     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    alu_cmd_t         cmd_reg, cmd_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [RES_W-1:0] rsp_data_reg, rsp_data_next;
    logic [3:0]       rsp_op_reg, rsp_op_next;
    logic [15:0]      op_count_reg, op_count_next;

    alu_cmd_t         fifo_push_data;
    alu_cmd_t         fifo_pop_data;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign fifo_push_data = '{s: alu_unit_e'(cmd_s), m: cmd_m, x: cmd_x, y: cmd_y};
    assign fifo_push      = cmd_valid && !fifo_full;

    alu_cmd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .data_t (alu_cmd_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cmd_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_op_reg    <= '0;
            op_count_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cmd_reg       <= cmd_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_op_reg    <= rsp_op_next;
            op_count_reg  <= op_count_next;
        end
    end

    // cmd_reg only loads on a pop, so the ALU inputs stay frozen through
    // SETTLE and RESP and keep the last command while idle.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cmd_next       = cmd_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_op_next    = rsp_op_reg;
        op_count_next  = op_count_reg;
        fifo_pop       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cmd_next   = fifo_pop_data;
                    cnt_next   = SETTLE_LOAD;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    rsp_data_next  = alu_z;
                    rsp_op_next    = op_tag(cmd_reg);
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    op_count_next  = op_count_reg + 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready = !fifo_full;
    assign alu_x     = cmd_reg.x;
    assign alu_y     = cmd_reg.y;
    assign alu_m     = cmd_reg.m;
    assign alu_s     = cmd_reg.s;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_op    = rsp_op_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a transaction scoreboard on a SETTLE_CYCLES=1
// instance plus directed settle-length and reset tests on a SETTLE_CYCLES=3 one.
module tb_alu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int S1    = 1;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: SETTLE_CYCLES=1, stub z = {x,y}
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]  cmd_s, cmd_m, alu_s, alu_m;
    logic [7:0]  cmd_x, cmd_y, alu_x, alu_y;
    logic [15:0] alu_z, rsp_data, op_count;
    logic [3:0]  rsp_op;
    assign alu_z = {alu_x, alu_y};

    alu_issue_ctrl #(.SETTLE_CYCLES(S1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_s(alu_s), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .busy(busy), .op_count(op_count)
    );

    // Instance B: SETTLE_CYCLES=3, stub z lags its inputs by one cycle
    logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, busy3;
    logic [1:0]  cmd_s3, cmd_m3, alu_s3, alu_m3;
    logic [7:0]  cmd_x3, cmd_y3, alu_x3, alu_y3;
    logic [15:0] alu_z3, rsp_data3, op_count3;
    logic [3:0]  rsp_op3;
    always @(posedge clk) alu_z3 <= {alu_x3, alu_y3};

    alu_issue_ctrl #(.SETTLE_CYCLES(3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_s(cmd_s3), .cmd_m(cmd_m3), .cmd_x(cmd_x3), .cmd_y(cmd_y3),
        .alu_x(alu_x3), .alu_y(alu_y3), .alu_m(alu_m3), .alu_s(alu_s3), .alu_z(alu_z3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_op(rsp_op3), .busy(busy3), .op_count(op_count3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: outstanding commands {s,m,x,y} in issue order.
    logic [19:0] q[$];
    logic [15:0] rsp_log[$];
    logic [15:0] mdl_count = '0;
    logic [19:0] prev_alu = '0;
    logic        prev_rsp_valid = 1'b0;
    int          stable_cnt = 0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        logic [19:0] cur_alu;
        cur_alu = {alu_s, alu_m, alu_x, alu_y};
        if (!rst_n) begin
            q.delete();
            mdl_count      = '0;
            prev_rsp_valid = 1'b0;
            stable_cnt     = 0;
        end else if (mon_en) begin
            if (cur_alu == prev_alu) stable_cnt++;
            else stable_cnt = 0;
            if ((cur_alu != prev_alu) && prev_rsp_valid)
                check("alu_held_in_resp", cur_alu, prev_alu);
            check("op_count", op_count, mdl_count);
            check("busy", busy, q.size() != 0);
            if (q.size() >= DEPTH + 1) check("cmd_ready_full", cmd_ready, 0);
            else if (q.size() < DEPTH) check("cmd_ready_space", cmd_ready, 1);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_without_cmd", rsp_valid, 0);
                end else begin
                    check("rsp_data", rsp_data, q[0][15:0]);
                    check("rsp_op", rsp_op, q[0][19:16]);
                    if (!prev_rsp_valid) begin
                        check("alu_matches_cmd", cur_alu, q[0]);
                        check("settle_len", stable_cnt >= S1, 1);
                    end
                end
            end
            if (cmd_valid && cmd_ready) q.push_back({cmd_s, cmd_m, cmd_x, cmd_y});
            if (rsp_valid && rsp_ready && (q.size() != 0)) begin
                $display("[TB] rsp data=%h op=%h count_before=%0d", rsp_data, rsp_op, mdl_count);
                rsp_log.push_back(rsp_data);
                void'(q.pop_front());
                mdl_count++;
            end
            prev_rsp_valid = rsp_valid;
        end
        prev_alu = cur_alu;
    end

    task automatic send(input logic [1:0] s, input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        int n;
        cmd_s = s; cmd_m = m; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("send_timeout", 1, 0);
        else tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send3(input logic [1:0] s, input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        int n;
        cmd_s3 = s; cmd_m3 = m; cmd_x3 = x; cmd_y3 = y; cmd_valid3 = 1'b1;
        n = 0;
        while (!cmd_ready3 && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready3) check("send3_timeout", 1, 0);
        else tick();
        cmd_valid3 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int held;
        int seen;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_s = '0; cmd_m = '0; cmd_x = '0; cmd_y = '0; rsp_ready = 1'b1;
        cmd_valid3 = 1'b0; cmd_s3 = '0; cmd_m3 = '0; cmd_x3 = '0; cmd_y3 = '0; rsp_ready3 = 1'b1;
        #1;
        check("reset_alu", {alu_s, alu_m, alu_x, alu_y}, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", {rsp_op, rsp_data}, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_op_count", op_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // Single op: accepted at edge T, pop at T+1, response visible after T+2
        cmd_s = 2'b11; cmd_m = 2'b01; cmd_x = 8'hA5; cmd_y = 8'h3C; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("single_no_rsp_T", rsp_valid, 0);
        tick();
        check("single_alu", {alu_s, alu_m, alu_x, alu_y}, 20'hDA53C);
        check("single_no_rsp_T1", rsp_valid, 0);
        check("single_busy", busy, 1);
        tick();
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_data", rsp_data, 16'hA53C);
        check("single_rsp_op", rsp_op, 4'hD);
        tick();
        check("single_rsp_done", rsp_valid, 0);
        check("single_op_count", op_count, 1);
        check("single_idle", busy, 0);

        // Fill and backpressure
        pulse_reset();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(2'b00, 2'b00, 8'(i), 8'h10);
        tick();
        tick();
        check("fill_cmd_ready_low", cmd_ready, 0);
        check("fill_rsp_first", rsp_data, 16'h0110);
        check("fill_stall_valid", rsp_valid, 1);
        rsp_log.delete();
        rsp_ready = 1'b1;
        send(2'b00, 2'b00, 8'h06, 8'h10);
        wait_idle("fill_drain_timeout");
        check("fill_rsp_count", rsp_log.size(), 6);
        for (int i = 0; i < 6 && i < rsp_log.size(); i++)
            check("fill_rsp_order", rsp_log[i], {8'(i + 1), 8'h10});
        check("fill_op_count", op_count, 6);

        // Counter wrap from a preloaded value
        force dut.op_count_reg = 16'hFFFE;
        mdl_count = 16'hFFFE;
        #1;
        release dut.op_count_reg;
        tick();
        check("wrap_preload", op_count, 16'hFFFE);
        send(2'b01, 2'b10, 8'h07, 8'h08);
        wait_idle("wrap1_timeout");
        check("wrap_ffff", op_count, 16'hFFFF);
        send(2'b10, 2'b11, 8'h09, 8'h0A);
        wait_idle("wrap2_timeout");
        check("wrap_zero", op_count, 16'h0000);

        // Settle length on the 3-cycle instance with a lagging ALU stub
        send3(2'b00, 2'b10, 8'h12, 8'h34);
        held = 0;
        for (int n = 0; n < 20 && !rsp_valid3; n++) begin
            @(negedge clk);
            if (!rsp_valid3 && alu_x3 == 8'h12 && alu_y3 == 8'h34) held++;
        end
        check("settle3_rsp_valid", rsp_valid3, 1);
        check("settle3_hold_cycles", held, 3);
        check("settle3_rsp_data", rsp_data3, 16'h1234);
        check("settle3_rsp_op", rsp_op3, 4'h2);
        tick();
        tick();
        check("settle3_op_count", op_count3, 1);

        // Reset while in SETTLE with two commands queued
        send3(2'b11, 2'b00, 8'h55, 8'h66);
        send3(2'b11, 2'b01, 8'h77, 8'h88);
        send3(2'b11, 2'b10, 8'h99, 8'hAA);
        check("midop_busy_before", busy3, 1);
        check("midop_alu_before", alu_x3, 8'h55);
        rst_n = 1'b0;
        #1;
        check("midop_async_alu", {alu_s3, alu_m3, alu_x3, alu_y3}, 0);
        check("midop_async_rsp_valid", rsp_valid3, 0);
        check("midop_async_cmd_ready", cmd_ready3, 1);
        check("midop_async_busy", busy3, 0);
        check("midop_async_op_count", op_count3, 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (rsp_valid3) seen++;
        end
        check("midop_no_rsp_after", seen, 0);
        check("midop_cmd_ready_after", cmd_ready3, 1);
        check("midop_busy_after", busy3, 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
